// File: rtl/arb_pkg.sv
// arb_pkg: shared widths, state encoding and default hold limit for the round-robin decode arbiter.
package arb_pkg;
   localparam int N_REQ        = 8;
   localparam int IDX_W        = 3;
   localparam int HOLD_W       = 4;
   localparam int MAX_HOLD_DEF = 4;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_decode_arbiter_dec.sv
// rr_decode_arbiter_dec: 3-to-8 enable decoder, y_o one-hot at index {a,b,c} when en_i is high.
module rr_decode_arbiter_dec (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       c_i,
   input  logic       en_i,
   output logic [7:0] y_o
);
   assign y_o = en_i ? 8'b1 << {a_i, b_i, c_i} : 8'h00;
endmodule

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin arbiter with bounded hold time driving a one-hot grant bus.
module rr_decode_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic [N_REQ-1:0] gnt,
   output logic             preempt
);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   state_t            state_q;
   logic [IDX_W-1:0]  ptr_q, idx_q;
   logic [HOLD_W-1:0] hold_q;
   logic              vld_q, pre_q;
   logic [N_REQ-1:0]  rot, others;
   logic [IDX_W-1:0]  ff, pick;
   // rotate so ptr sits at bit 0, take the lowest set bit, then rotate back
   always_comb begin
      rot = '0;
      for (int k = 0; k < N_REQ; k++) rot[k] = req[IDX_W'(ptr_q + IDX_W'(k))];
      ff = '0;
      for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) ff = IDX_W'(k);
   end
   assign pick   = ptr_q + ff;
   assign others = req & ~(N_REQ'(1) << idx_q);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
         vld_q   <= 1'b0;
         pre_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               pre_q <= 1'b0;
               if (|req) begin
                  idx_q   <= pick;
                  vld_q   <= 1'b1;
                  hold_q  <= HOLD_W'(1);
                  state_q <= GRANT;
               end
            end
            default: begin
               // release takes priority over preemption
               if (!req[idx_q] || (hold_q == HOLD_MAX && |others)) begin
                  pre_q   <= req[idx_q];
                  vld_q   <= 1'b0;
                  ptr_q   <= idx_q + IDX_W'(1);
                  hold_q  <= '0;
                  state_q <= IDLE;
               end else if (hold_q != HOLD_MAX) hold_q <= hold_q + HOLD_W'(1);
            end
         endcase
      end
   end
   assign gnt_idx = idx_q;
   assign gnt_vld = vld_q;
   assign preempt = pre_q;
   rr_decode_arbiter_dec u_dec (
      .a_i (idx_q[2]),
      .b_i (idx_q[1]),
      .c_i (idx_q[0]),
      .en_i(vld_q),
      .y_o (gnt)
   );
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: scoreboard bench; a reference model predicts outputs each edge, directed checks cover the key scenarios.
module tb_rr_decode_arbiter;
   localparam int MH = 4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'hFF;
   logic [2:0] gnt_idx;
   logic       gnt_vld, preempt;
   logic [7:0] gnt;
   int n_chk = 0, n_fail = 0;
   typedef struct packed {logic vld; logic [2:0] idx; logic [7:0] g; logic pre;} exp_t;
   exp_t sb_q[$];
   rr_decode_arbiter #(.MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt_idx(gnt_idx),
      .gnt_vld(gnt_vld), .gnt(gnt), .preempt(preempt)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // reference model, evaluated on the pre-edge request vector
   logic       m_st = 0, m_vld = 0, m_pre = 0;
   logic [2:0] m_ptr = 0, m_idx = 0;
   int         m_hold = 0;
   always @(posedge clk) begin
      exp_t e;
      bit   found;
      if (!rst_n) begin
         m_st = 0; m_vld = 0; m_pre = 0; m_ptr = 0; m_idx = 0; m_hold = 0;
      end else if (!m_st) begin
         m_pre = 0;
         found = 0;
         for (int k = 0; k < 8; k++) begin
            int j;
            j = (int'(m_ptr) + k) % 8;
            if (!found && req[j]) begin found = 1; m_idx = 3'(j); end
         end
         if (found) begin m_vld = 1; m_hold = 1; m_st = 1; end
      end else if (!req[m_idx]) begin
         m_vld = 0; m_st = 0; m_hold = 0; m_ptr = 3'((int'(m_idx) + 1) % 8);
      end else if (m_hold == MH && (req & ~(8'b1 << m_idx)) != 8'h00) begin
         m_vld = 0; m_st = 0; m_hold = 0; m_pre = 1; m_ptr = 3'((int'(m_idx) + 1) % 8);
      end else if (m_hold < MH) m_hold++;
      e.vld = m_vld; e.idx = m_idx; e.pre = m_pre;
      e.g   = m_vld ? 8'b1 << m_idx : 8'h00;
      sb_q.push_back(e);
   end
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("sb_vld", 32'(gnt_vld), 32'(e.vld));
         check("sb_idx", 32'(gnt_idx), 32'(e.idx));
         check("sb_gnt", 32'(gnt), 32'(e.g));
         check("sb_pre", 32'(preempt), 32'(e.pre));
      end
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      int seq[$];
      logic pv;
      // reset with all requests pending
      cyc(2);
      check("rst_vld", 32'(gnt_vld), 0);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_pre", 32'(preempt), 0);
      rst_n = 1'b1;
      req   = 8'h00;
      cyc(3);
      check("idle_vld", 32'(gnt_vld), 0);
      check("idle_gnt", 32'(gnt), 0);
      // single grant/release; ptr moves to 3
      req = 8'h04;
      cyc(1);
      check("sg_idx", 32'(gnt_idx), 2);
      check("sg_gnt", 32'(gnt), 32'h04);
      cyc(2);
      req = 8'h00;
      cyc(1);
      check("sg_rel", 32'(gnt), 0);
      req = 8'h09;
      cyc(1);
      check("sg_ptr3", 32'(gnt_idx), 3);
      req = 8'h00;
      cyc(2);
      // rotation between 0 and 7
      do_reset();
      pv = 0;
      for (int c = 0; c < 14; c++) begin
         req = 8'h81 & ~gnt;
         @(negedge clk);
         if (gnt_vld && !pv) seq.push_back(int'(gnt_idx));
         pv = gnt_vld;
      end
      check("rr_n", 32'(seq.size() >= 4), 1);
      for (int i = 0; i < 4 && i < seq.size(); i++) check("rr_seq", 32'(seq[i]), (i % 2) ? 7 : 0);
      // preempt with constant contention
      do_reset();
      req = 8'h03;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (k <= 3 || k == 10) check("pe_g0", 32'(gnt), 32'h01);
         if (k == 4 || k == 9) begin
            check("pe_pulse", 32'(preempt), 1);
            check("pe_gap", 32'(gnt), 0);
         end
         if (k >= 5 && k <= 8) check("pe_g1", 32'(gnt), 32'h02);
      end
      // no contention, then contention after saturation
      do_reset();
      req = 8'h10;
      cyc(1);
      for (int k = 0; k < 12; k++) begin
         check("nc_gnt", 32'(gnt), 32'h10);
         check("nc_pre", 32'(preempt), 0);
         @(negedge clk);
      end
      req = 8'h12;
      cyc(1);
      check("nc_pulse", 32'(preempt), 1);
      check("nc_gap", 32'(gnt), 0);
      cyc(1);
      check("nc_next", 32'(gnt_idx), 1);
      check("nc_nextv", 32'(gnt_vld), 1);
      // asynchronous reset mid-grant
      do_reset();
      req = 8'h20;
      for (int i = 0; i < 8 && gnt !== 8'h20; i++) @(negedge clk);
      check("ar_wait", 32'(gnt), 32'h20);
      #2 rst_n = 1'b0;
      #1;
      check("ar_gnt", 32'(gnt), 0);
      check("ar_vld", 32'(gnt_vld), 0);
      req = 8'h21;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ar_first", 32'(gnt_idx), 0);
      check("ar_firstg", 32'(gnt), 32'h01);
      cyc(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
